// File: rtl/fsk_mod_pkg.sv
// Shared types and constants for the FSK modulator and its demodulator counterpart.
package fsk_pkg;

  localparam int WORD_W       = 16;
  localparam int DEMOD_THRESH = 24;

  localparam int HALF_P0_DEF  = 16;
  localparam int HALF_P1_DEF  = 32;
  localparam int BIT_LEN_DEF  = 256;
  localparam int AMP_DEF      = 100;
  localparam int PRE_BITS_DEF = 8;

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_e;

  // Two's-complement square-wave level for the given polarity.
  function automatic logic [7:0] tone_level(input logic neg, input int amp);
    return neg ? 8'(256 - amp) : 8'(amp);
  endfunction

endpackage

// File: rtl/fsk_mod_if.sv
// Word-transfer handshake into the FSK modulator.
interface fsk_mod_if;
  import fsk_pkg::*;

  logic              tx_valid;
  logic [WORD_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: half-period counter, polarity and the registered output sample.
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int HALF_P0 = HALF_P0_DEF,
  parameter int HALF_P1 = HALF_P1_DEF,
  parameter int AMP     = AMP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en_i,
  input  logic              active_i,
  input  logic              bit_i,
  input  logic              restart_i,
  output logic              pol_o,
  output logic signed [7:0] sample_o
);

  localparam int HALF_W = $clog2(HALF_P1);

  logic [HALF_W-1:0] half_q, half_d, hp_last;
  logic              pol_q, pol_d;
  logic [7:0]        sample_q, sample_d;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    half_d   = half_q;
    pol_d    = pol_q;
    sample_d = sample_q;
    hp_last  = bit_i ? HALF_W'(HALF_P1 - 1) : HALF_W'(HALF_P0 - 1);
    if (sample_en_i) begin
      sample_d = active_i ? tone_level(pol_q, AMP) : 8'd0;
      // The sample above belongs to the current position; restart affects the next one.
      if (!active_i || restart_i) begin
        half_d = '0;
        pol_d  = 1'b0;
      end else if (half_q == hp_last) begin
        half_d = '0;
        pol_d  = ~pol_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= '0;
      pol_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      half_q   <= half_d;
      pol_q    <= pol_d;
      sample_q <= sample_d;
    end
  end

  assign pol_o    = pol_q;
  assign sample_o = sample_q;

endmodule

// File: rtl/fsk_mod.sv
// Binary FSK modulator: serialises a 16-bit word MSB first as square-wave samples.
// Define FSK_PREAMBLE_EN to prepend PRE_BITS alternating bits (1,0,1,...) to every frame.
module fsk_mod
  import fsk_pkg::*;
#(
  parameter int HALF_P0  = HALF_P0_DEF,
  parameter int HALF_P1  = HALF_P1_DEF,
  parameter int BIT_LEN  = BIT_LEN_DEF,
  parameter int AMP      = AMP_DEF,
  parameter int PRE_BITS = PRE_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en_i,
  fsk_mod_if.slave          tx,
  output logic signed [7:0] sample_out_o,
  output logic              bit_cur_o,
  output logic              bit_strobe_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SAMP_W = $clog2(BIT_LEN);
  localparam int IDX_W  = $clog2(WORD_W);
  localparam int PRE_W  = $clog2(PRE_BITS) + 1;

  if (HALF_P0 < 1 || HALF_P0 > DEMOD_THRESH) begin : g_bad_half_p0
    $error("HALF_P0 must be in 1..DEMOD_THRESH");
  end
  if (HALF_P1 <= DEMOD_THRESH) begin : g_bad_half_p1
    $error("HALF_P1 must exceed DEMOD_THRESH");
  end
  if ((BIT_LEN % (2 * HALF_P0)) != 0 || (BIT_LEN % (2 * HALF_P1)) != 0) begin : g_bad_bit_len
    $error("BIT_LEN must be a multiple of 2*HALF_P0 and 2*HALF_P1");
  end
  if (AMP < 1 || AMP > 127) begin : g_bad_amp
    $error("AMP must be in 1..127");
  end
  if (PRE_BITS < 1) begin : g_bad_pre_bits
    $error("PRE_BITS must be at least 1");
  end

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [SAMP_W-1:0] samp_q;
  logic [IDX_W-1:0]  idx_q;
  logic              tx_ready_q, busy_q, done_q, strobe_q;
  logic              last_samp, cur_bit, tone_pol;
  logic signed [7:0] tone_sample;

  assign last_samp = (samp_q == SAMP_W'(BIT_LEN - 1));

`ifdef FSK_PREAMBLE_EN
  logic [PRE_W-1:0] pre_q;
  assign cur_bit = (state_q == PRE) ? ~pre_q[0] : shreg_q[WORD_W-1];
`else
  assign cur_bit = shreg_q[WORD_W-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      samp_q     <= '0;
      idx_q      <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
`ifdef FSK_PREAMBLE_EN
      pre_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state.
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx.tx_valid && tx_ready_q) begin
            shreg_q    <= tx.tx_data;
            samp_q     <= '0;
            idx_q      <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FSK_PREAMBLE_EN
            pre_q      <= '0;
            state_q    <= PRE;
`else
            state_q    <= DATA;
`endif
          end
        end
`ifdef FSK_PREAMBLE_EN
        PRE: begin
          if (sample_en_i) begin
            strobe_q <= (samp_q == '0);
            if (last_samp) begin
              samp_q <= '0;
              if (pre_q == PRE_W'(PRE_BITS - 1)) begin
                pre_q   <= '0;
                state_q <= DATA;
              end else begin
                pre_q <= pre_q + 1'b1;
              end
            end else begin
              samp_q <= samp_q + 1'b1;
            end
          end
        end
`endif
        DATA: begin
          if (sample_en_i) begin
            strobe_q <= (samp_q == '0);
            if (last_samp) begin
              samp_q  <= '0;
              shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
              if (idx_q == IDX_W'(WORD_W - 1)) begin
                idx_q      <= '0;
                state_q    <= IDLE;
                done_q     <= 1'b1;
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              samp_q <= samp_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fsk_tone_gen #(
    .HALF_P0 (HALF_P0),
    .HALF_P1 (HALF_P1),
    .AMP     (AMP)
  ) u_tone (
    .clk         (clk),
    .rst         (rst),
    .sample_en_i (sample_en_i),
    .active_i    (busy_q),
    .bit_i       (cur_bit),
    .restart_i   (last_samp),
    .pol_o       (tone_pol),
    .sample_o    (tone_sample)
  );

  // An even number of half-periods per bit leaves the last sample of every bit negative.
  a_phase_continuous: assert property (@(posedge clk) disable iff (rst)
    (busy_q && sample_en_i && last_samp) |-> tone_pol);

  assign tx.tx_ready   = tx_ready_q;
  assign sample_out_o  = tone_sample;
  assign bit_cur_o     = cur_bit;
  assign bit_strobe_o  = strobe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_fsk_mod.sv
// Self-checking bench for fsk_mod: table-driven frames, random frames, handshake and reset corners.
module tb_fsk_mod;
  import fsk_pkg::*;

  localparam int BL  = BIT_LEN_DEF;
  localparam int HP0 = HALF_P0_DEF;
  localparam int HP1 = HALF_P1_DEF;
  localparam int AMP = AMP_DEF;
`ifdef FSK_PREAMBLE_EN
  localparam int PRE_N = PRE_BITS_DEF;
`else
  localparam int PRE_N = 0;
`endif
  localparam int NBITS = PRE_N + WORD_W;
  localparam int NSAMP = NBITS * BL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [7:0] sample_out;
  logic       bit_cur, bit_strobe, busy, done;

  fsk_mod_if bus ();

  always #5 clk = ~clk;

  fsk_mod dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en_i  (sample_en),
    .tx           (bus),
    .sample_out_o (sample_out),
    .bit_cur_o    (bit_cur),
    .bit_strobe_o (bit_strobe),
    .busy_o       (busy),
    .done_o       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: bit i of a frame, then sample n from the tone rules.
  function automatic logic model_bit(input logic [15:0] w, input int i);
    if (i < PRE_N) return (i % 2) == 0;
    return w[WORD_W - 1 - (i - PRE_N)];
  endfunction

  function automatic logic [7:0] model_sample(input logic [15:0] w, input int n);
    int hp;
    hp = model_bit(w, n / BL) ? HP1 : HP0;
    return (((n % BL) / hp) % 2 == 0) ? 8'(AMP) : 8'(256 - AMP);
  endfunction

  // Sign changes over the frame, starting from and returning to the idle level 0.
  function automatic int model_toggles(input logic [15:0] w);
    logic [7:0] v;
    logic       prev, s;
    int         cnt;
    prev = 1'b0;
    cnt  = 0;
    for (int n = 0; n < NSAMP; n++) begin
      v = model_sample(w, n);
      s = v[7];
      if (s != prev) cnt++;
      prev = s;
    end
    if (prev) cnt++;
    return cnt;
  endfunction

  task automatic send(input logic [15:0] w, input bit keep_valid, input string tag);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "/ready_before"}, 32'(bus.tx_ready), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    @(posedge clk); #1;
    check({tag, "/busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "/ready_after_accept"}, 32'(bus.tx_ready), 32'd0);
    if (!keep_valid) begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 16'($urandom);
    end
  endtask

  task automatic run_frame(input logic [15:0] word, input int div, input bit hold,
                           input logic [15:0] next_word, input int exp_toggles, input string tag);
    logic [7:0] samp[$];
    int         spos[$];
    logic       sbit[$];
    logic [7:0] v;
    logic       prev;
    logic [15:0] rec;
    bit         got_done;
    int         spurious, done_at, errs, toggles, run, budget;
    logic       ready_at_done, busy_at_done;
    got_done = 0; spurious = 0; done_at = -1;
    ready_at_done = 1'b0; busy_at_done = 1'b1;
    budget = NSAMP * div + 100;
    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      sample_en = (cyc % div) == 0;
      if (hold) bus.tx_data = 16'($urandom);
      @(posedge clk); #1;
      if (sample_en) begin
        samp.push_back(sample_out);
        if (bit_strobe) begin
          spos.push_back(samp.size() - 1);
          sbit.push_back(bit_cur);
        end
      end else if (bit_strobe || done) begin
        spurious++;
      end
      if (done) begin
        got_done      = 1;
        done_at       = samp.size();
        ready_at_done = bus.tx_ready;
        busy_at_done  = busy;
      end
    end
    check({tag, "/done_seen"}, 32'(got_done), 32'd1);
    check({tag, "/frame_len"}, 32'(done_at), 32'(NSAMP));
    check({tag, "/ready_with_done"}, 32'(ready_at_done), 32'd1);
    check({tag, "/busy_with_done"}, 32'(busy_at_done), 32'd0);
    check({tag, "/off_strobe_pulses"}, 32'(spurious), 32'd0);

    errs = 0;
    foreach (samp[i]) if (samp[i] !== model_sample(word, i)) errs++;
    check({tag, "/sample_errors"}, 32'(errs), 32'd0);
    check({tag, "/strobe_count"}, 32'(spos.size()), 32'(NBITS));
    errs = 0;
    foreach (spos[k])
      if (spos[k] != k * BL || sbit[k] !== model_bit(word, k) || samp[spos[k]] !== 8'(AMP)) errs++;
    check({tag, "/bit_start_errors"}, 32'(errs), 32'd0);

    // One more strobe: idle level, or the next word taken when tx_valid is held high.
    sample_en = 1'b1;
    if (hold) bus.tx_data = next_word;
    @(posedge clk); #1;
    check({tag, "/idle_sample"}, 32'(sample_out), 32'd0);
    check({tag, "/busy_after"}, 32'(busy), 32'(hold));
    samp.push_back(sample_out);

    toggles = 0;
    prev    = 1'b0;
    foreach (samp[i]) begin
      v = samp[i];
      if (v[7] != prev) toggles++;
      prev = v[7];
    end
    check({tag, "/sign_toggles"}, 32'(toggles), 32'(exp_toggles));

    // Zero-crossing demodulation: first half-period longer than the threshold means a 1.
    rec = '0;
    if (samp.size() > NSAMP) begin
      for (int b = PRE_N; b < NBITS; b++) begin
        run = 1;
        while (run < BL && samp[b * BL + run][7] == samp[b * BL][7]) run++;
        rec = {rec[14:0], (run > DEMOD_THRESH)};
      end
    end
    check({tag, "/loopback_word"}, 32'(rec), 32'(word));
    sample_en = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] word;
    int          div;
    int          exp_toggles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w1, w2;
    int          dn;
    logic [7:0]  held;

    vecs[0] = '{"all_zero", 16'h0000, 1, model_toggles(16'h0000)};
    vecs[1] = '{"all_one",  16'hFFFF, 1, model_toggles(16'hFFFF)};
    vecs[2] = '{"a5c3_div3", 16'hA5C3, 3, model_toggles(16'hA5C3)};
    vecs[3] = '{"8001",     16'h8001, 1, model_toggles(16'h8001)};
    vecs[4] = '{"5a5a",     16'h5A5A, 1, model_toggles(16'h5A5A)};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst          = 1'b1;
    sample_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset/sample_out", 32'(sample_out), 32'd0);
    check("reset/tx_ready", 32'(bus.tx_ready), 32'd1);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/bit_strobe", 32'(bit_strobe), 32'd0);
    check("reset/bit_cur", 32'(bit_cur), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle/sample_out", 32'(sample_out), 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].word, 1'b0, vecs[i].name);
      run_frame(vecs[i].word, vecs[i].div, 1'b0, 16'h0, vecs[i].exp_toggles, vecs[i].name);
    end

    for (int r = 0; r < 2; r++) begin
      w1 = 16'($urandom);
      dn = int'($urandom_range(1, 2));
      send(w1, 1'b0, $sformatf("rand%0d", r));
      run_frame(w1, dn, 1'b0, 16'h0, model_toggles(w1), $sformatf("rand%0d", r));
    end

    // tx_valid held high with scrambled tx_data: only the first word goes out, the next follows done.
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    send(w1, 1'b1, "hold1");
    run_frame(w1, 1, 1'b1, w2, model_toggles(w1), "hold1");
    bus.tx_valid = 1'b0;
    run_frame(w2, 1, 1'b0, 16'h0, model_toggles(w2), "hold2");

    // sample_en low holds everything; reset mid-frame then aborts without done.
    w1 = 16'h3C96;
    send(w1, 1'b0, "stall");
    held = sample_out;
    dn   = 0;
    sample_en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bit_strobe || done || sample_out !== held || !busy) dn++;
    end
    check("stall/frozen_cycles", 32'(dn), 32'd0);
    sample_en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("abort/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort/sample_out_async", 32'(sample_out), 32'd0);
    check("abort/busy_async", 32'(busy), 32'd0);
    check("abort/tx_ready_async", 32'(bus.tx_ready), 32'd1);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    check("abort/no_done", 32'(dn), 32'd0);

    w1 = 16'($urandom);
    send(w1, 1'b0, "post_reset");
    run_frame(w1, 1, 1'b0, 16'h0, model_toggles(w1), "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
